// File: rtl/pattern_fifo_checker.sv
// pattern_fifo_checker
//
// Read-side companion of the PATTERN_FIFO generator. Drains the FIFO while
// check_en is high, regenerates the expected word for the selected pattern and
// compares every word. It reports the words checked, the completed blocks, a
// saturating mismatch count and a capture of the first mismatch.
//
// It must come out of reset together with the generator, so that both sides
// start counting at word 0 of block 0.
//
// Parameters
//   WORD_CNT_W  log2 of words per block (16 matches the generator). Must be >= 2.
//   ERR_CNT_W   width of the saturating mismatch counter.
//
// Ports
//   digiclk         in   clock
//   resetn          in   asynchronous reset, active low
//   pattern[1:0]    in   0=INCR 1=DECR 2=0's/F's 3=5's/A's; latched on IDLE->RUN
//   check_en        in   level: drain and check while high
//   check_clear     in   sync pulse: clear the counters and the first-error capture
//   fifo_empty      in   FIFO empty flag
//   fifo_rd_data    in   FIFO read data, valid one cycle after an accepted read
//   fifo_re         out  FIFO read enable
//   busy            out  FSM not idle
//   err_flag        out  sticky, set on the first mismatch
//   err_cnt         out  mismatch count, saturating
//   chk_cnt[31:0]   out  words checked, wraps
//   blk_cnt[15:0]   out  completed blocks, wraps
//   first_err_word  out  chk_cnt value of the first mismatching word
//   first_err_data  out  received value of the first mismatch
//   first_err_exp   out  expected value of the first mismatch

module pattern_fifo_checker #(
    parameter int unsigned WORD_CNT_W = 16,
    parameter int unsigned ERR_CNT_W  = 32
) (
    input  logic                 digiclk,
    input  logic                 resetn,
    input  logic [1:0]           pattern,
    input  logic                 check_en,
    input  logic                 check_clear,
    input  logic                 fifo_empty,
    input  logic [31:0]          fifo_rd_data,
    output logic                 fifo_re,
    output logic                 busy,
    output logic                 err_flag,
    output logic [ERR_CNT_W-1:0] err_cnt,
    output logic [31:0]          chk_cnt,
    output logic [15:0]          blk_cnt,
    output logic [31:0]          first_err_word,
    output logic [31:0]          first_err_data,
    output logic [31:0]          first_err_exp
);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDrain
    } state_e;

    state_e state_q, state_d;

    logic [1:0]            pattern_q, pattern_d;
    logic                  rd_vld_q;
    logic [WORD_CNT_W-1:0] w_q, w_d;
    logic [15:0]           blk_q, blk_d;
    logic [31:0]           chk_q, chk_d;
    logic [ERR_CNT_W-1:0]  err_q, err_d;
    logic                  flag_q, flag_d;
    logic [31:0]           fe_word_q, fe_word_d;
    logic [31:0]           fe_data_q, fe_data_d;
    logic [31:0]           fe_exp_q, fe_exp_d;

    logic [31:0]           base_val;
    logic [31:0]           exp_word;
    logic                  mismatch;
    logic                  last_word;

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        pattern_d = pattern_q;
        unique case (state_q)
            StIdle: begin
                if (check_en) begin
                    state_d   = StRun;
                    pattern_d = pattern;
                end
            end
            StRun: begin
                if (!check_en) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                // A read accepted in the last RUN cycle is still checked here.
                if (!rd_vld_q) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign fifo_re = (state_q == StRun) && !fifo_empty;
    assign busy    = (state_q != StIdle);

    // ------------------------------------------------------------------
    // Expected word for the current block / word index
    // ------------------------------------------------------------------
    always_comb begin
        base_val = ({16'h0000, blk_q} << WORD_CNT_W) + 32'(w_q);
        unique case (pattern_q)
            2'd0:    exp_word = base_val;
            2'd1:    exp_word = ~base_val;
            2'd2:    exp_word = w_q[1] ? 32'hFFFF_FFFF : 32'h0000_0000;
            default: exp_word = w_q[1] ? 32'hAAAA_AAAA : 32'h5555_5555;
        endcase
    end

    assign mismatch  = rd_vld_q && (fifo_rd_data != exp_word);
    assign last_word = (w_q == {WORD_CNT_W{1'b1}});

    // ------------------------------------------------------------------
    // Counters and first-error capture
    // ------------------------------------------------------------------
    always_comb begin
        w_d       = w_q;
        blk_d     = blk_q;
        chk_d     = chk_q;
        err_d     = err_q;
        flag_d    = flag_q;
        fe_word_d = fe_word_q;
        fe_data_d = fe_data_q;
        fe_exp_d  = fe_exp_q;

        if (check_clear) begin
            // Clear wins over a same-cycle compare; that word is dropped.
            w_d       = '0;
            blk_d     = '0;
            chk_d     = '0;
            err_d     = '0;
            flag_d    = 1'b0;
            fe_word_d = '0;
            fe_data_d = '0;
            fe_exp_d  = '0;
        end else if (rd_vld_q) begin
            chk_d = chk_q + 32'd1;
            if (last_word) begin
                w_d   = '0;
                blk_d = blk_q + 16'd1;
            end else begin
                w_d = w_q + 1'b1;
            end
            if (mismatch) begin
                if (err_q != {ERR_CNT_W{1'b1}}) begin
                    err_d = err_q + 1'b1;
                end
                if (!flag_q) begin
                    flag_d    = 1'b1;
                    fe_word_d = chk_q;
                    fe_data_d = fifo_rd_data;
                    fe_exp_d  = exp_word;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge digiclk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= StIdle;
            pattern_q <= 2'd0;
            rd_vld_q  <= 1'b0;
            w_q       <= '0;
            blk_q     <= '0;
            chk_q     <= '0;
            err_q     <= '0;
            flag_q    <= 1'b0;
            fe_word_q <= '0;
            fe_data_q <= '0;
            fe_exp_q  <= '0;
        end else begin
            state_q   <= state_d;
            pattern_q <= pattern_d;
            rd_vld_q  <= fifo_re;
            w_q       <= w_d;
            blk_q     <= blk_d;
            chk_q     <= chk_d;
            err_q     <= err_d;
            flag_q    <= flag_d;
            fe_word_q <= fe_word_d;
            fe_data_q <= fe_data_d;
            fe_exp_q  <= fe_exp_d;
        end
    end

    assign err_flag       = flag_q;
    assign err_cnt        = err_q;
    assign chk_cnt        = chk_q;
    assign blk_cnt        = blk_q;
    assign first_err_word = fe_word_q;
    assign first_err_data = fe_data_q;
    assign first_err_exp  = fe_exp_q;

endmodule

// File: tb/tb_pattern_fifo_checker.sv
// Testbench for pattern_fifo_checker: table of run records plus hand-written
// multi-cycle sequences and randomized runs against a word-index model.
// A second instance with a 4-bit error counter shares all stimulus.

module tb_pattern_fifo_checker;

    logic        digiclk = 1'b0;
    logic        resetn;
    logic [1:0]  pattern;
    logic        check_en;
    logic        check_clear;
    logic        fifo_empty = 1'b1;
    logic [31:0] fifo_rd_data = 32'h0;

    logic        fifo_re, busy, err_flag;
    logic [31:0] err_cnt, chk_cnt, first_err_word, first_err_data, first_err_exp;
    logic [15:0] blk_cnt;

    logic        fifo_re4, busy4, err_flag4;
    logic [3:0]  err_cnt4;
    logic [31:0] chk_cnt4, first_err_word4, first_err_data4, first_err_exp4;
    logic [15:0] blk_cnt4;

    always #5 digiclk = ~digiclk;

    pattern_fifo_checker #(.WORD_CNT_W(16), .ERR_CNT_W(32)) dut (
        .digiclk(digiclk), .resetn(resetn), .pattern(pattern), .check_en(check_en),
        .check_clear(check_clear), .fifo_empty(fifo_empty), .fifo_rd_data(fifo_rd_data),
        .fifo_re(fifo_re), .busy(busy), .err_flag(err_flag), .err_cnt(err_cnt),
        .chk_cnt(chk_cnt), .blk_cnt(blk_cnt), .first_err_word(first_err_word),
        .first_err_data(first_err_data), .first_err_exp(first_err_exp)
    );

    pattern_fifo_checker #(.WORD_CNT_W(16), .ERR_CNT_W(4)) dut4 (
        .digiclk(digiclk), .resetn(resetn), .pattern(pattern), .check_en(check_en),
        .check_clear(check_clear), .fifo_empty(fifo_empty), .fifo_rd_data(fifo_rd_data),
        .fifo_re(fifo_re4), .busy(busy4), .err_flag(err_flag4), .err_cnt(err_cnt4),
        .chk_cnt(chk_cnt4), .blk_cnt(blk_cnt4), .first_err_word(first_err_word4),
        .first_err_data(first_err_data4), .first_err_exp(first_err_exp4)
    );

    // ---------------- FIFO model ----------------
    logic [31:0] fifo_q[$];
    int          n_popped = 0;
    int          gcnt = 0;
    bit          toggle3 = 1'b0;
    bit          rnd_gaps = 1'b0;

    always @(posedge digiclk) begin
        if (fifo_re && fifo_q.size() > 0) begin
            fifo_rd_data <= fifo_q.pop_front();
            n_popped     <= n_popped + 1;
        end else begin
            fifo_rd_data <= $urandom;
        end
        gcnt       <= gcnt + 1;
        fifo_empty <= (fifo_q.size() == 0) || (toggle3 && (gcnt % 6) < 3) ||
                      (rnd_gaps && $urandom_range(0, 2) == 0);
    end

    int viol = 0;
    always @(negedge digiclk) begin
        if (fifo_re && fifo_empty) viol <= viol + 1;
        if (fifo_re && !busy) viol <= viol + 1;
        if (fifo_re != fifo_re4 || busy != busy4) viol <= viol + 1;
    end

    // ---------------- checking helpers ----------------
    int          n_vec = 0;
    int          n_bad = 0;
    int unsigned k = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, expv);
        end
    endtask

    // Expected generator word by global word index since the last clear.
    function automatic logic [31:0] ref_exp(input logic [1:0] p, input logic [31:0] idx);
        case (p)
            2'd0:    return idx;
            2'd1:    return ~idx;
            2'd2:    return idx[1] ? 32'hFFFF_FFFF : 32'h0;
            default: return idx[1] ? 32'hAAAA_AAAA : 32'h5555_5555;
        endcase
    endfunction

    task automatic do_clear();
        @(negedge digiclk);
        check_clear = 1'b1;
        @(negedge digiclk);
        check_clear = 1'b0;
        k = 0;
    endtask

    task automatic push_words(input logic [1:0] p, input int n, input int b0,
                              input logic [31:0] v0, input int b1, input logic [31:0] v1);
        for (int i = 0; i < n; i++) begin
            if (i == b0)      fifo_q.push_back(v0);
            else if (i == b1) fifo_q.push_back(v1);
            else              fifo_q.push_back(ref_exp(p, k));
            k++;
        end
    endtask

    task automatic wait_drained(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge digiclk);
            if (fifo_q.size() == 0) break;
        end
        check("drain_words_left", fifo_q.size(), 0);
        repeat (3) @(negedge digiclk);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 20; i++) begin
            @(negedge digiclk);
            if (!busy) break;
        end
        check("busy_idle", busy, 0);
    endtask

    task automatic check_state(input string tag, input logic [31:0] e_chk, input logic [15:0] e_blk,
                               input logic [31:0] e_err, input logic e_flag, input logic [31:0] e_fw,
                               input logic [31:0] e_fd, input logic [31:0] e_fe);
        logic [3:0] e_err4;
        e_err4 = (e_err > 32'd15) ? 4'hF : e_err[3:0];
        check({tag, " chk_cnt"}, chk_cnt, e_chk);
        check({tag, " blk_cnt"}, blk_cnt, e_blk);
        check({tag, " err_cnt"}, err_cnt, e_err);
        check({tag, " err_cnt4"}, err_cnt4, e_err4);
        check({tag, " err_flag"}, err_flag, e_flag);
        check({tag, " first_err_word"}, first_err_word, e_fw);
        check({tag, " first_err_data"}, first_err_data, e_fd);
        check({tag, " first_err_exp"}, first_err_exp, e_fe);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        clr;
        logic [1:0]  pat;
        int          n;
        int          bad0;
        logic [31:0] badv0;
        int          bad1;
        logic [31:0] badv1;
        logic [31:0] e_chk;
        logic [15:0] e_blk;
        logic [31:0] e_err;
        logic        e_flag;
        logic [31:0] e_fw;
        logic [31:0] e_fd;
        logic [31:0] e_fe;
    } vec_t;

    vec_t        tbl[8];
    int          base;
    int          popped_at_drop;
    bit          found;
    logic [1:0]  rp;
    int          rn;
    logic [31:0] good, val, mask;
    logic [31:0] m_err, m_fw, m_fd, m_fe;
    logic        m_flag;

    initial begin
        // Mode0 through the block wrap (with a mode1 detour across the boundary).
        tbl[0] = '{1'b1, 2'd0, 65535, -1, 32'h0, -1, 32'h0, 32'd65535, 16'd0, 0, 1'b0, 0, 0, 0};
        tbl[1] = '{1'b0, 2'd1, 2, -1, 32'h0, -1, 32'h0, 32'd65537, 16'd1, 0, 1'b0, 0, 0, 0};
        tbl[2] = '{1'b0, 2'd0, 4463, -1, 32'h0, -1, 32'h0, 32'd70000, 16'd1, 0, 1'b0, 0, 0, 0};
        tbl[3] = '{1'b0, 2'd0, 2, -1, 32'h0, 1, 32'h0, 32'd70002, 16'd1, 1, 1'b1,
                   32'd70001, 32'h0, 32'h0001_1171};
        tbl[4] = '{1'b1, 2'd1, 4, 0, 32'h0, -1, 32'h0, 32'd4, 16'd0, 1, 1'b1,
                   0, 32'h0, 32'hFFFF_FFFF};
        tbl[5] = '{1'b1, 2'd3, 12, 6, 32'hAAAA_AAAB, 9, 32'h0, 32'd12, 16'd0, 2, 1'b1,
                   6, 32'hAAAA_AAAB, 32'hAAAA_AAAA};
        tbl[6] = '{1'b1, 2'd2, 8, 5, 32'h1234_5678, -1, 32'h0, 32'd8, 16'd0, 1, 1'b1,
                   5, 32'h1234_5678, 32'h0};
        tbl[7] = '{1'b0, 2'd2, 4, 0, 32'hFFFF_FFFF, -1, 32'h0, 32'd12, 16'd0, 2, 1'b1,
                   5, 32'h1234_5678, 32'h0};

        resetn = 1'b0; pattern = 2'd0; check_en = 1'b0; check_clear = 1'b0;
        repeat (3) @(negedge digiclk);
        check_state("reset", 0, 0, 0, 1'b0, 0, 0, 0);
        check("reset fifo_re", fifo_re, 0);
        check("reset busy", busy, 0);
        resetn = 1'b1;

        // Table-driven runs.
        for (int r = 0; r < 8; r++) begin
            if (tbl[r].clr) do_clear();
            @(negedge digiclk);
            pattern = tbl[r].pat;
            push_words(tbl[r].pat, tbl[r].n, tbl[r].bad0, tbl[r].badv0, tbl[r].bad1, tbl[r].badv1);
            check_en = 1'b1;
            wait_drained(tbl[r].n * 2 + 100);
            check_en = 1'b0;
            wait_idle();
            check_state($sformatf("row%0d", r), tbl[r].e_chk, tbl[r].e_blk, tbl[r].e_err,
                        tbl[r].e_flag, tbl[r].e_fw, tbl[r].e_fd, tbl[r].e_fe);
        end

        // Mode2 with empty toggling, a pattern change mid-run and a drop in flight.
        do_clear();
        pattern = 2'd2;
        push_words(2'd2, 30, -1, 0, -1, 0);
        toggle3 = 1'b1;
        base = n_popped;
        check_en = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge digiclk);
            if (n_popped - base == 3) pattern = 2'd0;
            if (fifo_re && (n_popped - base) >= 8) begin
                found = 1'b1;
                break;
            end
        end
        check("m2 inflight_seen", found, 1);
        check_en = 1'b0;
        popped_at_drop = n_popped - base;
        @(negedge digiclk);
        check("m2 drain_busy", busy, 1);
        check("m2 inflight_pop", n_popped - base, popped_at_drop + 1);
        wait_idle();
        toggle3 = 1'b0;
        check_state("m2", n_popped - base, 0, 0, 1'b0, 0, 0, 0);
        fifo_q.delete();

        // Saturation of the 4-bit counter, then clear coincident with a compare.
        do_clear();
        pattern = 2'd0;
        for (int i = 0; i < 20; i++) begin
            fifo_q.push_back(~ref_exp(2'd0, k));
            k++;
        end
        check_en = 1'b1;
        wait_drained(200);
        check_state("sat", 20, 0, 20, 1'b1, 0, 32'hFFFF_FFFF, 32'h0);
        check("sat chk_cnt4", chk_cnt4, 20);
        check("sat blk_cnt4", blk_cnt4, 0);
        check("sat err_flag4", err_flag4, 1);
        check("sat first_err_word4", first_err_word4, 0);
        check("sat first_err_data4", first_err_data4, 32'hFFFF_FFFF);
        check("sat first_err_exp4", first_err_exp4, 0);
        fifo_q.push_back(32'h0BAD_0BAD);
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge digiclk);
            if (fifo_re) begin
                found = 1'b1;
                break;
            end
        end
        check("clr read_seen", found, 1);
        @(negedge digiclk);
        check_clear = 1'b1;
        @(negedge digiclk);
        check_clear = 1'b0;
        k = 0;
        check_state("clr_vs_cmp", 0, 0, 0, 1'b0, 0, 0, 0);
        push_words(2'd0, 1, -1, 0, -1, 0);
        wait_drained(50);
        check_state("after_clr", 1, 0, 0, 1'b0, 0, 0, 0);
        check_en = 1'b0;
        wait_idle();

        // Reset mid-block, generator restarted with it.
        do_clear();
        pattern = 2'd0;
        push_words(2'd0, 200, -1, 0, -1, 0);
        check_en = 1'b1;
        repeat (40) @(negedge digiclk);
        resetn = 1'b0;
        fifo_q.delete();
        k = 0;
        @(negedge digiclk);
        check_state("in_reset", 0, 0, 0, 1'b0, 0, 0, 0);
        check("in_reset fifo_re", fifo_re, 0);
        check("in_reset busy", busy, 0);
        resetn = 1'b1;
        push_words(2'd0, 6, -1, 0, -1, 0);
        wait_drained(100);
        check_state("post_reset", 6, 0, 0, 1'b0, 0, 0, 0);
        check_en = 1'b0;
        wait_idle();

        // Randomized runs against the word-index model.
        for (int it = 0; it < 15; it++) begin
            do_clear();
            rp = 2'($urandom_range(0, 3));
            rn = $urandom_range(1, 80);
            rnd_gaps = 1'($urandom_range(0, 1));
            m_err = 0; m_flag = 1'b0; m_fw = 0; m_fd = 0; m_fe = 0;
            pattern = rp;
            for (int i = 0; i < rn; i++) begin
                good = ref_exp(rp, i);
                val  = good;
                if ($urandom_range(0, 5) == 0) begin
                    mask = $urandom;
                    if (mask == 0) mask = 32'h1;
                    val = good ^ mask;
                end
                if (val != good) begin
                    m_err++;
                    if (!m_flag) begin
                        m_flag = 1'b1; m_fw = i; m_fd = val; m_fe = good;
                    end
                end
                fifo_q.push_back(val);
            end
            check_en = 1'b1;
            wait_drained(rn * 6 + 100);
            check_en = 1'b0;
            wait_idle();
            rnd_gaps = 1'b0;
            check_state($sformatf("rand%0d", it), rn, 0, m_err, m_flag, m_fw, m_fd, m_fe);
        end

        check("fifo_re_rules", viol, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
